// File: rtl/slide_window_ctrl.sv
// slide_window_ctrl: round-robin event arbiter feeding a sticky sliding window
// Optional statistics counters enabled by SLIDE_WINDOW_CTRL_STATS_EN.
module slide_window_ctrl #(
  parameter int VECTOR_SIZE = 16,
  parameter int NUM_REQ     = 4,
  parameter int STEP_DIV    = 8,
  parameter int HIT_THRESH  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_hit,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic                   slide_en,
  output logic                   slide_in,
  output logic [VECTOR_SIZE-1:0] window,
  output logic                   busy,
  output logic                   loop_detected,
  output logic [15:0]            step_count,
  output logic [15:0]            hit_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DET
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [VECTOR_SIZE-1:0] r_window;
  logic                   r_pending;
  logic [HW-1:0]          r_phase;
  logic [PW-1:0]          r_ptr;

  logic [NUM_REQ-1:0]     w_grant;
  logic [PW-1:0]          w_gidx;
  logic                   w_found;
  logic                   w_hit;
  logic                   w_slide;
  logic                   w_sin;
  logic [VECTOR_SIZE-1:0] w_post;
  logic                   w_det;
  logic                   w_clear;
  int                     w_idx;
  int                     w_pop;

  // Round-robin pick: first valid requester above the last granted one
  always_comb begin
    w_grant = '0;
    w_gidx  = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    if (r_state == S_RUN && !reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_idx = (int'(r_ptr) + k) % NUM_REQ;
        if (!w_found && req_valid[w_idx]) begin
          w_found        = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_gidx         = PW'(w_idx);
        end
      end
    end
  end

  assign w_hit   = |(w_grant & req_hit);
  assign w_slide = (r_state == S_DRAIN) ||
                   (r_state == S_RUN &&
                    r_phase == HW'(STEP_DIV - 1));
  assign w_sin   = r_pending | w_hit | r_window[0];
  assign w_post  = {r_window[VECTOR_SIZE-2:0], w_sin};

  // Popcount of the window as it would look after this slide
  always_comb begin
    w_pop = 0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      w_pop = w_pop + int'(w_post[i]);
    end
  end

  assign w_det = w_slide && (w_pop >= HIT_THRESH);

  // Next state; detection overrides both stop and the drain exit
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_det)     w_next = S_DET;
        else if (stop) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_next = w_det ? S_DET : S_IDLE;
      end
      S_DET: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, window, pending bit, step phase and arbitration pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_window  <= '0;
      r_pending <= 1'b0;
      r_phase   <= '0;
      r_ptr     <= PW'(NUM_REQ - 1);
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_window  <= '0;
        r_pending <= 1'b0;
        r_phase   <= '0;
      end else if (w_slide) begin
        r_window  <= w_post;
        r_pending <= 1'b0;
        r_phase   <= '0;
      end else begin
        if (w_hit) r_pending <= 1'b1;
        if (r_state == S_RUN) r_phase <= r_phase + 1'b1;
      end
      if (w_found) r_ptr <= w_gidx;
    end
  end

`ifdef SLIDE_WINDOW_CTRL_STATS_EN
  logic [15:0] r_steps;
  logic [15:0] r_hits;

  // Saturating slide and granted-hit counters, cleared by start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_steps <= '0;
      r_hits  <= '0;
    end else if (w_clear) begin
      r_steps <= '0;
      r_hits  <= '0;
    end else begin
      if (w_slide && r_steps != 16'hFFFF) r_steps <= r_steps + 16'd1;
      if (w_hit && r_hits != 16'hFFFF)    r_hits  <= r_hits + 16'd1;
    end
  end

  assign step_count = reset ? 16'd0 : r_steps;
  assign hit_count  = reset ? 16'd0 : r_hits;
`else
  assign step_count = 16'd0;
  assign hit_count  = 16'd0;
`endif

  assign req_grant     = w_grant;
  assign slide_en      = w_slide && !reset;
  assign slide_in      = w_slide && !reset && w_sin;
  assign window        = reset ? '0 : r_window;
  assign busy          = !reset &&
                         (r_state == S_RUN || r_state == S_DRAIN);
  assign loop_detected = !reset && (r_state == S_DET);

endmodule

// File: tb/tb_slide_window_ctrl.sv
// tb_slide_window_ctrl: directed checks of arbitration, sliding,
// detection, drain and async reset for slide_window_ctrl.
module tb_slide_window_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [3:0]  req_valid;
  logic [3:0]  req_hit;
  logic [3:0]  req_grant;
  logic        slide_en;
  logic        slide_in;
  logic [15:0] window;
  logic        busy;
  logic        loop_detected;
  logic [15:0] step_count;
  logic [15:0] hit_count;

  int checks = 0;
  int fails  = 0;

  slide_window_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .req_valid     (req_valid),
    .req_hit       (req_hit),
    .req_grant     (req_grant),
    .slide_en      (slide_en),
    .slide_in      (slide_in),
    .window        (window),
    .busy          (busy),
    .loop_detected (loop_detected),
    .step_count    (step_count),
    .hit_count     (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  logic [15:0] exp_steps;
  logic [15:0] exp_hits;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    req_valid = 4'b1111;
    req_hit   = 4'b1111;
    #2;
    chk("rst_grant", 32'(req_grant), 32'h0);
    chk("rst_slide", 32'(slide_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_window", 32'(window), 32'h0);
    chk("rst_loop", 32'(loop_detected), 32'h0);
    chk("rst_steps", 32'(step_count), 32'h0);
    tick();
    tick();
    reset     = 1'b0;
    req_valid = 4'b0000;
    req_hit   = 4'b0000;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // round-robin over all four, slide on the eighth cycle
    do_start();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr_grant%0d", c), 32'(req_grant),
          32'(4'b0001 << (c % 4)));
      chk($sformatf("rr_slide%0d", c), 32'(slide_en),
          (c == 7) ? 32'h1 : 32'h0);
      tick();
    end
    chk("rr_window", 32'(window), 32'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    #1;
    chk("drain0_slide", 32'(slide_en), 32'h1);
    chk("drain0_grant", 32'(req_grant), 32'h0);
    chk("drain0_busy", 32'(busy), 32'h1);
    tick();
    chk("drain0_idle", 32'(busy), 32'h0);
    req_valid = 4'b0000;

    // single hit from requester 2, then sticky newest bit
    do_start();
    req_valid = 4'b0100;
    req_hit   = 4'b0100;
    #1;
    chk("h2_grant", 32'(req_grant), 32'h4);
    tick();
    req_valid = 4'b0000;
    req_hit   = 4'b0000;
    for (int c = 1; c < 7; c++) tick();
    chk("h2_slide_en", 32'(slide_en), 32'h1);
    chk("h2_slide_in", 32'(slide_in), 32'h1);
    tick();
    chk("h2_win1", 32'(window), 32'h0001);
    for (int c = 0; c < 7; c++) tick();
    chk("h2_sticky_in", 32'(slide_in), 32'h1);
    tick();
    chk("h2_win2", 32'(window), 32'h0003);
    do_stop();

    // stop mid-step with a pending hit
    do_start();
    req_valid = 4'b0001;
    req_hit   = 4'b0001;
    tick();
    req_valid = 4'b0000;
    req_hit   = 4'b0000;
    tick();
    stop = 1'b1;
    tick();
    stop      = 1'b0;
    req_valid = 4'b1111;
    chk("dr_slide_en", 32'(slide_en), 32'h1);
    chk("dr_slide_in", 32'(slide_in), 32'h1);
    chk("dr_grant", 32'(req_grant), 32'h0);
    tick();
    req_valid = 4'b0000;
    chk("dr_idle", 32'(busy), 32'h0);
    chk("dr_window", 32'(window), 32'h0001);

    // start with stop together in RUN acts as stop
    do_start();
    tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", 32'(busy), 32'h1);
    chk("ss_slide", 32'(slide_en), 32'h1);
    chk("ss_slide_in", 32'(slide_in), 32'h0);
    tick();
    chk("ss_idle", 32'(busy), 32'h0);
    chk("ss_window", 32'(window), 32'h0);

    // statistics: five granted hits over three slides
    do_start();
    req_valid = 4'b1111;
    req_hit   = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      if (c == 5) begin
        req_valid = 4'b0000;
        req_hit   = 4'b0000;
      end
      tick();
    end
`ifdef SLIDE_WINDOW_CTRL_STATS_EN
    exp_steps = 16'd3;
    exp_hits  = 16'd5;
`else
    exp_steps = 16'd0;
    exp_hits  = 16'd0;
`endif
    chk("st_steps", 32'(step_count), 32'(exp_steps));
    chk("st_hits", 32'(hit_count), 32'(exp_hits));
    chk("st_window", 32'(window), 32'h0007);
    do_stop();

    // continuous hits reach the threshold on the twelfth slide
    do_start();
    req_valid = 4'b1111;
    req_hit   = 4'b1111;
    for (int c = 0; c < 96; c++) begin
      if (c == 95) begin
        chk("det_pre_loop", 32'(loop_detected), 32'h0);
        chk("det_last_slide", 32'(slide_en), 32'h1);
      end
      tick();
    end
    chk("det_loop", 32'(loop_detected), 32'h1);
    chk("det_window", 32'(window), 32'h0FFF);
    chk("det_grant", 32'(req_grant), 32'h0);
    chk("det_busy", 32'(busy), 32'h0);
    tick();
    tick();
    chk("det_hold_win", 32'(window), 32'h0FFF);
    chk("det_hold_slide", 32'(slide_en), 32'h0);
    chk("det_hold_loop", 32'(loop_detected), 32'h1);
    do_start();
    chk("det_restart_loop", 32'(loop_detected), 32'h0);
    chk("det_restart_win", 32'(window), 32'h0);
    chk("det_restart_busy", 32'(busy), 32'h1);

    // asynchronous reset in the middle of a run
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_grant", 32'(req_grant), 32'h0);
    chk("ar_slide", 32'(slide_en), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_window", 32'(window), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_idle", 32'(busy), 32'h0);
    do_start();
    #1;
    chk("ar_first_grant", 32'(req_grant), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
